// File: rtl/bin_sweep_sequencer_pkg.sv
// Shared widths, default parameters and state encoding for the bin sweep
// sequencer and its capture pipe.
package bin_sweep_sequencer_pkg;

    localparam int LANES    = 16;
    localparam int LANE_W   = 18;
    localparam int ORIENT_W = 9;
    localparam int MAG_W    = 9;
    localparam int BIN_W    = 13;

    localparam int NUM_BINS_DEF    = 8;
    localparam int BIN_WIDTH_DEF   = 45;
    localparam int BIN_LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Edge of bin k in degrees, truncated to the 9-bit limit bus. The top
    // edge of the last default bin is 360, which still fits.
    function automatic logic [ORIENT_W-1:0] bin_edge(
        input logic [7:0]          k,
        input logic [ORIENT_W-1:0] width
    );
        logic [16:0] prod;
        prod = 17'(k) * 17'(width);
        return prod[ORIENT_W-1:0];
    endfunction

endpackage

// File: rtl/bin_sweep_sequencer_capture_pipe.sv
// Tag shift register that follows each loaded bin window through the
// summation latency, plus the histogram slots the returned sums land in.
module bin_capture_pipe
    import bin_sweep_sequencer_pkg::*;
#(
    parameter int NUM_BINS    = NUM_BINS_DEF,
    parameter int BIN_LATENCY = BIN_LATENCY_DEF,
    localparam int TAG_W      = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1,
    localparam int DEPTH      = BIN_LATENCY + 1,
    localparam int CNT_W      = $clog2(NUM_BINS + 1)
) (
    input  logic                      iclk,
    input  logic                      ireset,
    input  logic                      clear_i,
    input  logic                      tag_valid_i,
    input  logic [TAG_W-1:0]          tag_idx_i,
    input  logic [BIN_W-1:0]          bin_value_i,
    output logic [BIN_W*NUM_BINS-1:0] hist_o,
    output logic                      all_captured_o
);

    logic [DEPTH-1:0]                  tag_vld_q;
    logic [DEPTH-1:0][TAG_W-1:0]       tag_idx_q;
    logic [NUM_BINS-1:0][BIN_W-1:0]    hist_q;
    logic [CNT_W-1:0]                  cap_cnt_q;

    // Each stage is one clock edge; a tag leaving the last stage marks the
    // edge on which that bin's sum is present on bin_value_i.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            tag_vld_q <= '0;
            tag_idx_q <= '0;
        end else begin
            tag_vld_q[0] <= tag_valid_i;
            tag_idx_q[0] <= tag_idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    // Capture the returned sum into its slot and count bins for the frame.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            hist_q    <= '0;
            cap_cnt_q <= '0;
        end else if (clear_i) begin
            cap_cnt_q <= '0;
        end else if (tag_vld_q[DEPTH-1]) begin
            hist_q[tag_idx_q[DEPTH-1]] <= bin_value_i;
            cap_cnt_q                  <= cap_cnt_q + 1'b1;
        end
    end

    assign hist_o         = hist_q;
    assign all_captured_o = (cap_cnt_q == CNT_W'(NUM_BINS));

endmodule

// File: rtl/bin_sweep_sequencer.sv
// Initiator side of the 16-lane orientation-bin summation interface: packs
// serial gradient samples into lanes, sweeps bin windows over the limit
// ports, and hands the captured histogram to the descriptor stage.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | accepting samples into lanes; oready high
// SWEEP | loading one bin window per cycle onto the limit ports
// DRAIN | limits parked at 0/0, waiting for the last bin sums to return
// DONE  | histogram valid, held until the consumer accepts it
module bin_sweep_sequencer
    import bin_sweep_sequencer_pkg::*;
#(
    parameter int NUM_BINS    = NUM_BINS_DEF,
    parameter int BIN_WIDTH   = BIN_WIDTH_DEF,
    parameter int BIN_LATENCY = BIN_LATENCY_DEF
) (
    input  logic                      iclk,
    input  logic                      ireset,
    input  logic                      ivalid,
    input  logic [ORIENT_W-1:0]       iorient,
    input  logic [MAG_W-1:0]          imag,
    input  logic                      iflush,
    output logic                      oready,
    output logic [LANES*LANE_W-1:0]   olines,
    output logic [ORIENT_W-1:0]       olower_limit,
    output logic [ORIENT_W-1:0]       oupper_limit,
    input  logic [BIN_W-1:0]          ibin_value,
    output logic [BIN_W*NUM_BINS-1:0] ohist,
    output logic                      ohist_valid,
    input  logic                      ihist_ready
);

    localparam logic [1:0] S_FILL  = FILL;
    localparam logic [1:0] S_SWEEP = SWEEP;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    localparam int WR_W   = $clog2(LANES);
    localparam int BIDX_W = $clog2(NUM_BINS + 1);
    localparam int TAG_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    logic [1:0]                     state_q, state_d;
    logic [WR_W-1:0]                wr_idx_q, wr_idx_d;
    logic [LANES-1:0][LANE_W-1:0]   lanes_q, lanes_d;
    logic [BIDX_W-1:0]              bin_idx_q, bin_idx_d;
    logic [ORIENT_W-1:0]            lower_q, lower_d;
    logic [ORIENT_W-1:0]            upper_q, upper_d;
    logic                           hist_valid_q, hist_valid_d;

    logic                           xfer;
    logic                           load_vld;
    logic [TAG_W-1:0]               load_idx;
    logic                           cap_clear;
    logic                           all_captured;
    logic [ORIENT_W-1:0]            width_9;

    assign width_9 = ORIENT_W'(BIN_WIDTH);
    assign oready  = (state_q == S_FILL);
    assign xfer    = ivalid && oready;

    // Next-state logic. Loading a bin window always uses bin_idx_q, which is
    // 0 in FILL, so the SWEEP entry edge loads bin 0 through the same path.
    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        lanes_d      = lanes_q;
        bin_idx_d    = bin_idx_q;
        lower_d      = lower_q;
        upper_d      = upper_q;
        hist_valid_d = hist_valid_q;
        load_vld     = 1'b0;
        load_idx     = '0;
        cap_clear    = 1'b0;

        case (state_q)
            S_FILL: begin
                if (xfer) begin
                    lanes_d[wr_idx_q] = {iorient, imag};
                    wr_idx_d          = wr_idx_q + 1'b1;
                end
                if ((xfer && (wr_idx_q == WR_W'(LANES - 1))) ||
                    (iflush && (xfer || (wr_idx_q != '0)))) begin
                    state_d   = S_SWEEP;
                    lower_d   = bin_edge(8'(bin_idx_q), width_9);
                    upper_d   = bin_edge(8'(bin_idx_q + 1'b1), width_9);
                    bin_idx_d = bin_idx_q + 1'b1;
                    load_vld  = 1'b1;
                    load_idx  = bin_idx_q[TAG_W-1:0];
                end
            end

            S_SWEEP: begin
                if (bin_idx_q == BIDX_W'(NUM_BINS)) begin
                    state_d = S_DRAIN;
                    lower_d = '0;
                    upper_d = '0;
                end else begin
                    lower_d   = bin_edge(8'(bin_idx_q), width_9);
                    upper_d   = bin_edge(8'(bin_idx_q + 1'b1), width_9);
                    bin_idx_d = bin_idx_q + 1'b1;
                    load_vld  = 1'b1;
                    load_idx  = bin_idx_q[TAG_W-1:0];
                end
            end

            S_DRAIN: begin
                if (all_captured) begin
                    state_d      = S_DONE;
                    hist_valid_d = 1'b1;
                end
            end

            S_DONE: begin
                if (ihist_ready) begin
                    state_d      = S_FILL;
                    hist_valid_d = 1'b0;
                    lanes_d      = '0;
                    wr_idx_d     = '0;
                    bin_idx_d    = '0;
                    cap_clear    = 1'b1;
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State, lane buffer and limit registers; reset aborts any frame.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q      <= S_FILL;
            wr_idx_q     <= '0;
            lanes_q      <= '0;
            bin_idx_q    <= '0;
            lower_q      <= '0;
            upper_q      <= '0;
            hist_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            lanes_q      <= lanes_d;
            bin_idx_q    <= bin_idx_d;
            lower_q      <= lower_d;
            upper_q      <= upper_d;
            hist_valid_q <= hist_valid_d;
        end
    end

    bin_capture_pipe #(
        .NUM_BINS    (NUM_BINS),
        .BIN_LATENCY (BIN_LATENCY)
    ) u_capture (
        .iclk           (iclk),
        .ireset         (ireset),
        .clear_i        (cap_clear),
        .tag_valid_i    (load_vld),
        .tag_idx_i      (load_idx),
        .bin_value_i    (ibin_value),
        .hist_o         (ohist),
        .all_captured_o (all_captured)
    );

    assign olines       = lanes_q;
    assign olower_limit = lower_q;
    assign oupper_limit = upper_q;
    assign ohist_valid  = hist_valid_q;

endmodule

// File: tb/tb_bin_sweep_sequencer.sv
// Bench for bin_sweep_sequencer paired with a behavioural 16-lane
// bin-summation block (three-edge latency from limit load to sum).
module tb_bin_sweep_sequencer;
    import bin_sweep_sequencer_pkg::*;

    localparam int NB = 8;
    localparam int BW = 45;
    localparam int HW = BIN_W * NB;

    logic          iclk = 1'b0;
    logic          ireset = 1'b0;
    logic          ivalid = 1'b0;
    logic          iflush = 1'b0;
    logic          ihist_ready = 1'b0;
    logic [8:0]    iorient = '0;
    logic [8:0]    imag = '0;
    logic          oready;
    logic [287:0]  olines;
    logic [8:0]    olower_limit;
    logic [8:0]    oupper_limit;
    logic [12:0]   ibin_value;
    logic [HW-1:0] ohist;
    logic          ohist_valid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_cyc = 0;
    int acc[NB];
    int nsamp = 0;
    logic [HW-1:0] exp_q[$];
    logic [HW-1:0]  hist_snap;
    logic [287:0]   lines_snap;

    logic [12:0] s1 = '0;
    logic [12:0] s2 = '0;
    logic [12:0] s3 = '0;

    bin_sweep_sequencer dut (
        .iclk         (iclk),
        .ireset       (ireset),
        .ivalid       (ivalid),
        .iorient      (iorient),
        .imag         (imag),
        .iflush       (iflush),
        .oready       (oready),
        .olines       (olines),
        .olower_limit (olower_limit),
        .oupper_limit (oupper_limit),
        .ibin_value   (ibin_value),
        .ohist        (ohist),
        .ohist_valid  (ohist_valid),
        .ihist_ready  (ihist_ready)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    function automatic logic [12:0] bin_sum(input logic [287:0] lines,
                                            input logic [8:0] lo,
                                            input logic [8:0] hi);
        int s = 0;
        for (int i = 0; i < 16; i++) begin
            logic [8:0] o;
            logic [8:0] m;
            o = lines[18*i+9 +: 9];
            m = lines[18*i +: 9];
            if (o >= lo && o < hi) s += int'(m);
        end
        return 13'(s);
    endfunction

    // Summation block: registered compare/add, then two delay stages.
    always @(posedge iclk) begin
        s1 <= bin_sum(olines, olower_limit, oupper_limit);
        s2 <= s1;
        s3 <= s2;
    end
    assign ibin_value = s3;

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        logic [HW-1:0] e;
        e = '0;
        for (int k = 0; k < NB; k++) begin
            e[13*k +: 13] = 13'(acc[k]);
            acc[k] = 0;
        end
        exp_q.push_back(e);
        nsamp = 0;
    endtask

    task automatic send(input int o, input int m, input bit fl);
        check("oready_before_xfer", 288'(oready), 288'(1'b1));
        ivalid  = 1'b1;
        iorient = 9'(o);
        imag    = 9'(m);
        iflush  = fl;
        @(posedge iclk); #1;
        ivalid = 1'b0;
        iflush = 1'b0;
        if (o < 360) acc[o / BW] += m;
        nsamp++;
        if (nsamp == 16 || fl) begin
            push_expected();
            a_cyc = cyc;
        end
    endtask

    task automatic send_group(input int o, input int m);
        for (int i = 0; i < 16; i++) send(o, m, 1'b0);
    endtask

    task automatic wait_hist(input string tag);
        int n = 0;
        while (ohist_valid !== 1'b1 && n < 40) begin
            @(posedge iclk); #1;
            n++;
        end
        check({tag, "_valid"}, 288'(ohist_valid), 288'(1'b1));
        check({tag, "_latency"}, 288'(cyc - a_cyc), 288'(12));
        check({tag, "_queue"}, 288'(exp_q.size()), 288'(1));
        if (exp_q.size() > 0) check({tag, "_hist"}, 288'(ohist), 288'(exp_q.pop_front()));
    endtask

    task automatic handshake(input string tag);
        ihist_ready = 1'b1;
        @(posedge iclk); #1;
        ihist_ready = 1'b0;
        check({tag, "_hs_valid"}, 288'(ohist_valid), 288'(1'b0));
        check({tag, "_hs_oready"}, 288'(oready), 288'(1'b1));
        check({tag, "_hs_lines"}, 288'(olines), 288'(0));
    endtask

    initial begin
        for (int k = 0; k < NB; k++) acc[k] = 0;

        // reset state
        repeat (2) @(posedge iclk);
        #1;
        check("rst_oready", 288'(oready), 288'(1'b1));
        check("rst_hist_valid", 288'(ohist_valid), 288'(1'b0));
        check("rst_hist", 288'(ohist), 288'(0));
        check("rst_lines", 288'(olines), 288'(0));
        check("rst_lower", 288'(olower_limit), 288'(0));
        check("rst_upper", 288'(oupper_limit), 288'(0));
        ireset = 1'b1;
        @(posedge iclk); #1;
        check("post_rst_oready", 288'(oready), 288'(1'b1));

        // full group, with the limit sweep checked edge by edge
        send_group(10, 100);
        for (int k = 0; k <= NB; k++) begin
            if (k > 0) begin
                @(posedge iclk); #1;
            end
            check("sweep_lower", 288'(olower_limit), 288'(k < NB ? k * BW : 0));
            check("sweep_upper", 288'(oupper_limit), 288'(k < NB ? (k + 1) * BW : 0));
            check("sweep_oready", 288'(oready), 288'(1'b0));
            check("sweep_hist_valid", 288'(ohist_valid), 288'(1'b0));
        end
        wait_hist("full");
        handshake("full");

        // bin boundaries, 360 stored but counted nowhere
        send(44, 1, 1'b0);
        send(45, 1, 1'b0);
        send(359, 1, 1'b0);
        send(360, 1, 1'b0);
        send(0, 1, 1'b1);
        check("bnd_lane3", 288'(olines[3*18 +: 18]), 288'({9'd360, 9'd1}));
        check("bnd_upper_lanes", 288'(olines[287:90]), 288'(0));
        wait_hist("bnd");
        handshake("bnd");

        // backpressure in DONE with ivalid pulses
        for (int i = 0; i < 16; i++) send(i * 23, i + 1, 1'b0);
        wait_hist("bp");
        hist_snap  = ohist;
        lines_snap = olines;
        for (int i = 0; i < 5; i++) begin
            ivalid  = (i % 2 == 0);
            iorient = 9'd5;
            imag    = 9'd77;
            @(posedge iclk); #1;
            check("bp_hist_stable", 288'(ohist), 288'(hist_snap));
            check("bp_lines_stable", 288'(olines), 288'(lines_snap));
            check("bp_oready", 288'(oready), 288'(1'b0));
            check("bp_valid_held", 288'(ohist_valid), 288'(1'b1));
        end
        ivalid = 1'b0;
        handshake("bp");

        // partial flush on the third sample; lanes must start at index 0
        send(100, 511, 1'b0);
        send(100, 511, 1'b0);
        send(100, 511, 1'b1);
        check("part_lane0", 288'(olines[17:0]), 288'({9'd100, 9'd511}));
        check("part_lane2", 288'(olines[53:36]), 288'({9'd100, 9'd511}));
        check("part_zero_lanes_a", 288'(olines[287:54]), 288'(0));
        repeat (5) @(posedge iclk);
        #1;
        check("part_zero_lanes_mid", 288'(olines[287:54]), 288'(0));
        wait_hist("part");
        handshake("part");

        // reset while bin 4 is on the limit ports
        send_group(50, 3);
        repeat (4) @(posedge iclk);
        #1;
        check("rs_lower_bin4", 288'(olower_limit), 288'(180));
        check("rs_upper_bin4", 288'(oupper_limit), 288'(225));
        ireset = 1'b0;
        #1;
        check("rs_oready", 288'(oready), 288'(1'b1));
        check("rs_hist_valid", 288'(ohist_valid), 288'(1'b0));
        check("rs_hist", 288'(ohist), 288'(0));
        check("rs_lines", 288'(olines), 288'(0));
        check("rs_lower", 288'(olower_limit), 288'(0));
        check("rs_upper", 288'(oupper_limit), 288'(0));
        #2;
        ireset = 1'b1;
        exp_q.delete();
        @(posedge iclk); #1;
        send_group(200, 7);
        wait_hist("after_rst");
        handshake("after_rst");

        // peak magnitude into one bin
        send_group(300, 511);
        wait_hist("peak");
        check("peak_bin6", 288'(ohist[13*6 +: 13]), 288'(8176));
        handshake("peak");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_sweep_sequencer.md
Name: bin_sweep_sequencer

Overview:
- Initiator side of the 16-lane orientation-bin summation interface.
- Accepts a serial stream of gradient samples {orientation, magnitude} and packs 16 of them into parallel 18-bit lanes.
- Sweeps NUM_BINS orientation windows through the lower/upper limit ports of the bin-summation block, then captures each returned bin sum.
- Presents the finished histogram with a valid/ready handshake to the descriptor stage.

Parameters:
- NUM_BINS, 8, orientation bins per histogram.
- BIN_WIDTH, 45, degrees per bin; bin k covers [k*BIN_WIDTH, (k+1)*BIN_WIDTH).
- BIN_LATENCY, 3, clock edges from the edge that loads bin-k limits to the edge that makes ibin_value valid for bin k.

Ports:
- iclk  in  1  clock.
- ireset  in  1  asynchronous, active-low reset.
- ivalid  in  1  sample valid.
- iorient  in  9  sample orientation, 0..359 degrees.
- imag  in  9  sample magnitude.
- iflush  in  1  close a partial group (fewer than 16 samples) and start the sweep.
- oready  out  1  sample accept; a sample transfers on ivalid && oready.
- olines  out  288  lane i = olines[18i+17:18i] = {orient[8:0], mag[8:0]}.
- olower_limit  out  9  lower bound of the current bin, inclusive.
- oupper_limit  out  9  upper bound of the current bin, exclusive.
- ibin_value  in  13  bin sum returned by the summation block.
- ohist  out  13*NUM_BINS  bin k = ohist[13k+12:13k].
- ohist_valid  out  1  histogram valid.
- ihist_ready  in  1  consumer accept.

Behaviour:
- Reset (asynchronous, active-low):
  - state = FILL, so oready = 1 during and after reset.
  - Lane buffer, wr_idx, bin_idx, capture count, olower_limit, oupper_limit, ohist and ohist_valid all 0.
- oready is combinational: 1 iff state == FILL.
- States: FILL, SWEEP, DRAIN, DONE.
- FILL:
  - Each transfer writes {iorient, imag} into lane wr_idx, then wr_idx increments.
  - iorient is stored unclamped; values >= 360 match no bin.
  - On the 16th transfer, go to SWEEP.
  - iflush with wr_idx > 0 goes to SWEEP; unwritten lanes keep 0, so they contribute 0.
  - iflush and ivalid together: the sample is accepted first, then the flush applies.
  - iflush with wr_idx == 0 and no transfer is ignored.
- SWEEP entry: at the edge of entry (edge A), olower = 0 and oupper = BIN_WIDTH are loaded.
- SWEEP:
  - At edge A+k, bin k limits are loaded: k*BIN_WIDTH and (k+1)*BIN_WIDTH.
  - After bin NUM_BINS-1, at edge A+NUM_BINS, limits return to 0/0 (empty window) and state goes to DRAIN.
- Lanes are held constant from A until DONE exits.
- Capture: ibin_value for bin k is sampled at edge A+k+BIN_LATENCY+1 into ohist slot k. A tag shift register of depth BIN_LATENCY+1 tracks which bin each edge captures.
- DRAIN → DONE: at edge A+NUM_BINS+BIN_LATENCY+1 (edge A+12 with defaults), ohist_valid rises.
- DONE:
  - ohist and ohist_valid hold until ihist_ready.
  - On the handshake edge: ohist_valid = 0, lane buffer and wr_idx cleared, state = FILL.
  - oready returns in the next cycle.
- Widths:
  - Maximum bin sum is 16*511 = 8176, which fits in 13 bits; no saturation.
  - Limit arithmetic is 9-bit; the top limit is 360.
- Reset mid-operation (any state) aborts the frame; no partial histogram is ever emitted.

Decomposition:
- Shared package holds:
  - LANES = 16, LANE_W = 18, ORIENT_W = 9, MAG_W = 9, BIN_W = 13.
  - Default NUM_BINS and BIN_WIDTH.
  - State enum {FILL, SWEEP, DRAIN, DONE}.
- One natural sub-module: bin_capture_pipe, the BIN_LATENCY+1 deep tag shift register plus the ohist capture registers.

Test Plan:
- Bench pairs the DUT with the 16-lane bin-summation block.
- Full group: 16 samples of orient 10, mag 100 → ohist bin0 = 1600, bins 1..7 = 0. ohist_valid rises exactly 12 cycles after the 16th transfer edge.
- Boundaries: samples with orient 44, 45, 359, 360, 0, each mag 1 (rest zero, then iflush) → bin0 = 2, bin1 = 1, bin7 = 1, orient 360 counted nowhere.
- Partial flush: 3 samples of orient 100, mag 511, with iflush on the 3rd → bin2 = 1533, others 0; lanes 3..15 = 0 throughout the sweep.
- Backpressure: ihist_ready held low for 5 cycles in DONE → ohist stable and oready = 0. ivalid pulses are not accepted; wr_idx stays 0 until after the handshake.
- Reset in SWEEP (bin_idx = 4): ireset low → all outputs 0 immediately and oready = 1. The next full group (16 samples of orient 200, mag 7) → bin4 = 112, others 0.
- Peak magnitude: 16 samples of orient 300, mag 511 → bin6 = 8176, no overflow.
